// File: rtl/riscv_i32_ifetch_mem_adapter.sv
// Instruction-fetch adapter: turns halfword-aligned fetch requests into 32-bit SRAM word reads.
// Optional one-word buffer enabled by defining RISCV_I32_IFETCH_WORD_BUFFER_EN.
module riscv_i32_ifetch_mem_adapter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ifetch_req__flush_pipeline,
  input  logic [2:0]  ifetch_req__req_type,
  input  logic [31:0] ifetch_req__address,
  input  logic        ifetch_invalidate,
  input  logic        mem_wait,
  input  logic [31:0] mem_read_data,
  input  logic        mem_read_error,
  output logic        ifetch_resp__valid,
  output logic [31:0] ifetch_resp__data,
  output logic        ifetch_resp__error,
  output logic        mem_read_enable,
  output logic [29:0] mem_address
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_CAPTURE, S_RESP} state_t;

  state_t      state, state_nxt;
  logic [29:0] word_a, word_a_nxt;
  logic        straddle, straddle_nxt;
  logic [29:0] rd_addr, rd_addr_nxt;
  logic [15:0] lo_half, lo_half_nxt;
  logic [31:0] resp_data, resp_data_nxt;
  logic        resp_error, resp_error_nxt;

  logic [29:0] req_a;
  logic        req_go;
  logic        flush;
  logic        hit_a;
  logic [31:0] buf_rdata;
  logic        buf_wr;
  logic        unused_addr0;

  assign req_a        = ifetch_req__address[31:2];
  assign flush        = ifetch_req__flush_pipeline;
  assign req_go       = (|ifetch_req__req_type) && !flush;
  assign unused_addr0 = ifetch_req__address[0];
  // A flushed capture still fills the buffer; only the response is dropped.
  assign buf_wr       = (state == S_CAPTURE) && !mem_read_error;

`ifdef RISCV_I32_IFETCH_WORD_BUFFER_EN
  logic        buf_valid;
  logic [29:0] buf_tag;
  logic [31:0] buf_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= '0;
    end else begin
      if (ifetch_invalidate) buf_valid <= 1'b0;
      else if (buf_wr)       buf_valid <= 1'b1;
      if (buf_wr) begin
        buf_tag  <= rd_addr;
        buf_data <= mem_read_data;
      end
    end
  end

  assign hit_a     = buf_valid && (buf_tag == req_a);
  assign buf_rdata = buf_data;
`else
  logic unused_inv;
  logic unused_buf_wr;
  assign unused_inv    = ifetch_invalidate;
  assign unused_buf_wr = buf_wr;
  assign hit_a         = 1'b0;
  assign buf_rdata     = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      word_a     <= '0;
      straddle   <= 1'b0;
      rd_addr    <= '0;
      lo_half    <= '0;
      resp_data  <= '0;
      resp_error <= 1'b0;
    end else begin
      state      <= state_nxt;
      word_a     <= word_a_nxt;
      straddle   <= straddle_nxt;
      rd_addr    <= rd_addr_nxt;
      lo_half    <= lo_half_nxt;
      resp_data  <= resp_data_nxt;
      resp_error <= resp_error_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    word_a_nxt     = word_a;
    straddle_nxt   = straddle;
    rd_addr_nxt    = rd_addr;
    lo_half_nxt    = lo_half;
    resp_data_nxt  = resp_data;
    resp_error_nxt = resp_error;
    case (state)
      S_IDLE: begin
        if (req_go) begin
          word_a_nxt   = req_a;
          straddle_nxt = ifetch_req__address[1];
          if (hit_a && !ifetch_req__address[1]) begin
            state_nxt      = S_RESP;
            resp_data_nxt  = buf_rdata;
            resp_error_nxt = 1'b0;
          end else if (hit_a) begin
            // Straddle with the low word buffered: only A+1 goes to memory.
            state_nxt   = S_READ;
            lo_half_nxt = buf_rdata[31:16];
            rd_addr_nxt = req_a + 30'd1;
          end else begin
            state_nxt   = S_READ;
            rd_addr_nxt = req_a;
          end
        end
      end
      S_READ: begin
        if (flush)          state_nxt = S_IDLE;
        else if (!mem_wait) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (flush) begin
          state_nxt = S_IDLE;
        end else if (mem_read_error) begin
          state_nxt      = S_RESP;
          resp_data_nxt  = '0;
          resp_error_nxt = 1'b1;
        end else if (straddle && (rd_addr == word_a)) begin
          state_nxt   = S_READ;
          lo_half_nxt = mem_read_data[31:16];
          rd_addr_nxt = word_a + 30'd1;
        end else begin
          state_nxt      = S_RESP;
          resp_error_nxt = 1'b0;
          resp_data_nxt  = straddle ? {mem_read_data[15:0], lo_half} : mem_read_data;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign ifetch_resp__valid = (state == S_RESP) && !flush;
  assign ifetch_resp__data  = resp_data;
  assign ifetch_resp__error = resp_error;
  assign mem_read_enable    = (state == S_READ);
  assign mem_address        = (state == S_READ) ? rd_addr : '0;

endmodule

// File: tb/tb_riscv_i32_ifetch_mem_adapter.sv
// Bench for riscv_i32_ifetch_mem_adapter: directed table, hand sequences, random traffic vs a word-level model.
module tb_riscv_i32_ifetch_mem_adapter;

`ifdef RISCV_I32_IFETCH_WORD_BUFFER_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ifetch_req__flush_pipeline;
  logic [2:0]  ifetch_req__req_type;
  logic [31:0] ifetch_req__address;
  logic        ifetch_invalidate;
  logic        mem_wait;
  logic [31:0] mem_read_data;
  logic        mem_read_error;
  logic        ifetch_resp__valid;
  logic [31:0] ifetch_resp__data;
  logic        ifetch_resp__error;
  logic        mem_read_enable;
  logic [29:0] mem_address;

  riscv_i32_ifetch_mem_adapter dut (
    .clk                        (clk),
    .reset_n                    (reset_n),
    .ifetch_req__flush_pipeline (ifetch_req__flush_pipeline),
    .ifetch_req__req_type       (ifetch_req__req_type),
    .ifetch_req__address        (ifetch_req__address),
    .ifetch_invalidate          (ifetch_invalidate),
    .mem_wait                   (mem_wait),
    .mem_read_data              (mem_read_data),
    .mem_read_error             (mem_read_error),
    .ifetch_resp__valid         (ifetch_resp__valid),
    .ifetch_resp__data          (ifetch_resp__data),
    .ifetch_resp__error         (ifetch_resp__error),
    .mem_read_enable            (mem_read_enable),
    .mem_address                (mem_address)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [logic [29:0]];
  bit          err_map [logic [29:0]];
  logic [29:0] rd_log [$];
  logic [29:0] exp_rds [$];

  // reference buffer
  bit          mb_v;
  logic [29:0] mb_t;
  logic [31:0] mb_d;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memrd(input logic [29:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[13:0], a[17:0]} ^ 32'h5A5A_C3C3;
  endfunction

  // Word-level view: list the words memory must supply and the resulting instruction.
  task automatic model(input logic [31:0] addr, output logic [31:0] d, output logic e);
    logic [29:0] a, b;
    logic [15:0] lo;
    logic [31:0] w;
    a = addr[31:2];
    b = a + 30'd1;
    exp_rds.delete();
    d = '0;
    e = 1'b0;
    if (BUF_EN && mb_v && mb_t == a) begin
      w  = mb_d;
      if (!addr[1]) begin d = w; return; end
      lo = w[31:16];
    end else begin
      exp_rds.push_back(a);
      if (err_map.exists(a)) begin e = 1'b1; return; end
      w = memrd(a);
      mb_v = 1'b1; mb_t = a; mb_d = w;
      if (!addr[1]) begin d = w; return; end
      lo = w[31:16];
    end
    exp_rds.push_back(b);
    if (err_map.exists(b)) begin e = 1'b1; return; end
    w = memrd(b);
    mb_v = 1'b1; mb_t = b; mb_d = w;
    d = {w[15:0], lo};
  endtask

  task automatic drive(input logic [2:0] rt, input logic [31:0] addr, input logic fl,
                       input logic inv, input logic wt, input logic [31:0] rd, input logic re);
    @(negedge clk);
    ifetch_req__req_type       = rt;
    ifetch_req__address        = addr;
    ifetch_req__flush_pipeline = fl;
    ifetch_invalidate          = inv;
    mem_wait                   = wt;
    mem_read_data              = rd;
    mem_read_error             = re;
    #1;
  endtask

  task automatic idle(input logic inv);
    drive(3'd0, $urandom, 1'b0, inv, 1'(($urandom_range(0, 1))), $urandom, 1'b0);
    chk("idle_valid", ifetch_resp__valid, 1'b0);
    chk("idle_rd_en", mem_read_enable, 1'b0);
    if (inv) mb_v = 1'b0;
  endtask

  // Holds a request and plays the SRAM until a response appears or the budget runs out.
  task automatic run_req(input logic [31:0] addr, input int waits, output bit got,
                         output logic [31:0] d, output logic e, output int lat);
    int wcnt;
    bit acc, was_wait;
    logic [29:0] acc_a, wait_a;
    got = 0; d = '0; e = 1'b0; lat = -1;
    acc = 0; was_wait = 0; wcnt = 0; acc_a = '0; wait_a = '0;
    rd_log.delete();
    for (int cyc = 0; cyc < 60 && !got; cyc++) begin
      @(negedge clk);
      ifetch_req__req_type       = 3'($urandom_range(1, 7));
      ifetch_req__address        = addr;
      ifetch_req__flush_pipeline = 1'b0;
      ifetch_invalidate          = 1'b0;
      mem_read_data              = acc ? memrd(acc_a) : $urandom;
      mem_read_error             = acc ? err_map.exists(acc_a) : 1'b0;
      acc = 0;
      #1;
      if (mem_read_enable) begin
        if (was_wait) chk("addr_stable_in_wait", mem_address, wait_a);
        if (wcnt < waits) begin
          mem_wait = 1'b1; wcnt++; was_wait = 1; wait_a = mem_address;
        end else begin
          mem_wait = 1'b0; wcnt = 0; was_wait = 0;
          acc = 1; acc_a = mem_address; rd_log.push_back(mem_address);
        end
      end else begin
        mem_wait = 1'($urandom_range(0, 1));
        was_wait = 0;
        chk("addr_zero_when_idle", mem_address, 30'd0);
      end
      if (ifetch_resp__valid) begin
        got = 1; d = ifetch_resp__data; e = ifetch_resp__error; lat = cyc;
      end
    end
  endtask

  task automatic do_req(input logic [31:0] addr, input int waits);
    logic [31:0] ed, d;
    logic ee, e;
    bit got;
    int lat, elat;
    model(addr, ed, ee);
    elat = (exp_rds.size() == 0) ? 1 : 2 * exp_rds.size() + 1 + waits * exp_rds.size();
    run_req(addr, waits, got, d, e, lat);
    chk("resp_seen", got, 1'b1);
    if (got) begin
      chk("resp_data", d, ed);
      chk("resp_error", e, ee);
      chk("resp_latency", lat, elat);
    end
    chk("read_count", rd_log.size(), exp_rds.size());
    for (int i = 0; i < rd_log.size() && i < exp_rds.size(); i++)
      chk("read_addr", rd_log[i], exp_rds[i]);
  endtask

  typedef struct {
    logic        wr_en;
    logic [29:0] wr_a;
    logic [31:0] wr_d;
    logic [1:0]  err_op;
    logic [29:0] err_a;
    logic        inv;
    logic [31:0] addr;
    int          waits;
    logic [31:0] exp_d;
    logic        exp_e;
    int          exp_lat;
    int          exp_nrd;
    logic [29:0] exp_rd0;
  } vec_t;

  vec_t vt [15];

  initial begin
    logic [31:0] d, md;
    logic e, me;
    bit got;
    int lat;

    vt[0]  = '{1'b1, 30'h400, 32'h0000_0013, 2'd0, 30'h0, 1'b0, 32'h0000_1000, 0, 32'h0000_0013, 1'b0, 3, 1, 30'h400};
    vt[1]  = '{1'b0, 30'h0, 32'h0, 2'd0, 30'h0, 1'b0, 32'h0000_1000, 0, 32'h0000_0013, 1'b0, BUF_EN ? 1 : 3, BUF_EN ? 0 : 1, 30'h400};
    vt[2]  = '{1'b1, 30'h400, 32'hAAAA_BBBB, 2'd0, 30'h0, 1'b1, 32'h0000_1002, 0, 32'hDDDD_AAAA, 1'b0, 5, 2, 30'h400};
    vt[3]  = '{1'b0, 30'h0, 32'h0, 2'd0, 30'h0, 1'b0, 32'h0000_1004, 0, 32'hCCCC_DDDD, 1'b0, BUF_EN ? 1 : 3, BUF_EN ? 0 : 1, 30'h401};
    vt[4]  = '{1'b0, 30'h0, 32'h0, 2'd0, 30'h0, 1'b0, 32'hFFFF_FFFE, 0, 32'hDEF0_1234, 1'b0, 5, 2, 30'h3FFF_FFFF};
    vt[5]  = '{1'b0, 30'h0, 32'h0, 2'd0, 30'h0, 1'b0, 32'h0000_0000, 0, 32'h9ABC_DEF0, 1'b0, BUF_EN ? 1 : 3, BUF_EN ? 0 : 1, 30'h0};
    vt[6]  = '{1'b0, 30'h0, 32'h0, 2'd0, 30'h0, 1'b0, 32'h0000_3000, 0, 32'h1111_2222, 1'b0, 3, 1, 30'hC00};
    vt[7]  = '{1'b0, 30'h0, 32'h0, 2'd0, 30'h0, 1'b0, 32'h0000_3002, 0, 32'h4444_1111, 1'b0, BUF_EN ? 3 : 5, BUF_EN ? 1 : 2, BUF_EN ? 30'hC01 : 30'hC00};
    vt[8]  = '{1'b0, 30'h0, 32'h0, 2'd0, 30'h0, 1'b0, 32'h0000_3002, 0, 32'h4444_1111, 1'b0, 5, 2, 30'hC00};
    vt[9]  = '{1'b0, 30'h0, 32'h0, 2'd0, 30'h0, 1'b1, 32'h0000_1000, 3, 32'hAAAA_BBBB, 1'b0, 6, 1, 30'h400};
    vt[10] = '{1'b0, 30'h0, 32'h0, 2'd1, 30'h500, 1'b0, 32'h0000_1402, 0, 32'h0, 1'b1, 3, 1, 30'h500};
    vt[11] = '{1'b0, 30'h0, 32'h0, 2'd2, 30'h500, 1'b0, 32'h0000_1402, 0, 32'h8888_5555, 1'b0, 5, 2, 30'h500};
    vt[12] = '{1'b0, 30'h0, 32'h0, 2'd1, 30'h601, 1'b0, 32'h0000_1802, 0, 32'h0, 1'b1, 5, 2, 30'h600};
    vt[13] = '{1'b0, 30'h0, 32'h0, 2'd2, 30'h601, 1'b0, 32'h0000_1802, 0, 32'h0708_0102, 1'b0, BUF_EN ? 3 : 5, BUF_EN ? 1 : 2, BUF_EN ? 30'h601 : 30'h600};
    vt[14] = '{1'b0, 30'h0, 32'h0, 2'd0, 30'h0, 1'b0, 32'h0000_1803, 0, 32'h0708_0102, 1'b0, 5, 2, 30'h600};

    mem[30'h401]       = 32'hCCCC_DDDD;
    mem[30'h3FFF_FFFF] = 32'h1234_5678;
    mem[30'h0]         = 32'h9ABC_DEF0;
    mem[30'hC00]       = 32'h1111_2222;
    mem[30'hC01]       = 32'h3333_4444;
    mem[30'h500]       = 32'h5555_6666;
    mem[30'h501]       = 32'h7777_8888;
    mem[30'h600]       = 32'h0102_0304;
    mem[30'h601]       = 32'h0506_0708;
    mb_v = 1'b0; mb_t = '0; mb_d = '0;

    reset_n = 1'b0;
    ifetch_req__flush_pipeline = 1'b0;
    ifetch_req__req_type       = 3'd0;
    ifetch_req__address        = '0;
    ifetch_invalidate          = 1'b0;
    mem_wait                   = 1'b0;
    mem_read_data              = '0;
    mem_read_error             = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", ifetch_resp__valid, 1'b0);
    chk("rst_data",  ifetch_resp__data,  32'h0);
    chk("rst_error", ifetch_resp__error, 1'b0);
    chk("rst_rd_en", mem_read_enable,    1'b0);
    chk("rst_addr",  mem_address,        30'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      if (vt[i].wr_en) mem[vt[i].wr_a] = vt[i].wr_d;
      if (vt[i].err_op == 2'd1) err_map[vt[i].err_a] = 1'b1;
      if (vt[i].err_op == 2'd2) err_map.delete(vt[i].err_a);
      if (vt[i].inv) idle(1'b1);
      model(vt[i].addr, md, me);
      run_req(vt[i].addr, vt[i].waits, got, d, e, lat);
      chk($sformatf("vec%0d_seen", i), got, 1'b1);
      chk($sformatf("vec%0d_data", i), d, vt[i].exp_d);
      chk($sformatf("vec%0d_error", i), e, vt[i].exp_e);
      chk($sformatf("vec%0d_latency", i), lat, vt[i].exp_lat);
      chk($sformatf("vec%0d_reads", i), rd_log.size(), vt[i].exp_nrd);
      if (vt[i].exp_nrd > 0 && rd_log.size() > 0)
        chk($sformatf("vec%0d_rd0", i), rd_log[0], vt[i].exp_rd0);
    end

    // Flush while a read is stalled: no response, back to idle.
    drive(3'd1, 32'h0000_2000, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
    drive(3'd0, 32'h0000_2000, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0);
    chk("flush_read_en", mem_read_enable, 1'b1);
    chk("flush_read_addr", mem_address, 30'h800);
    chk("flush_read_valid", ifetch_resp__valid, 1'b0);
    drive(3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("flush_after_en", mem_read_enable, 1'b0);
    chk("flush_after_valid", ifetch_resp__valid, 1'b0);
    drive(3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("flush_after2_valid", ifetch_resp__valid, 1'b0);

    // Flush during capture: word still lands in the buffer, no response.
    drive(3'd1, 32'h0000_2400, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    drive(3'd1, 32'h0000_2400, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("flcap_rd_addr", mem_address, 30'h900);
    drive(3'd0, 32'h0, 1'b1, 1'b0, 1'b0, memrd(30'h900), 1'b0);
    chk("flcap_valid", ifetch_resp__valid, 1'b0);
    mb_v = 1'b1; mb_t = 30'h900; mb_d = memrd(30'h900);
    drive(3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("flcap_after_valid", ifetch_resp__valid, 1'b0);
    chk("flcap_after_en", mem_read_enable, 1'b0);
    do_req(32'h0000_2400, 0);
    idle(1'b1);
    do_req(32'h0000_2400, 0);

    // Reset mid-read abandons the transaction immediately.
    drive(3'd1, 32'h0000_2800, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
    drive(3'd1, 32'h0000_2800, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
    chk("rstmid_en_before", mem_read_enable, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("rstmid_en", mem_read_enable, 1'b0);
    chk("rstmid_addr", mem_address, 30'h0);
    chk("rstmid_valid", ifetch_resp__valid, 1'b0);
    mb_v = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    ifetch_req__req_type = 3'd0;
    do_req(32'h0000_2800, 0);

    // Random traffic against the model.
    for (int n = 0; n < 250; n++) begin
      logic [29:0] w;
      logic [31:0] a;
      case ($urandom_range(0, 3))
        0:       w = 30'h3FFF_FFFE + 30'($urandom_range(0, 3));
        default: w = 30'h700 + 30'($urandom_range(0, 5));
      endcase
      a = {w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
      err_map.delete();
      if ($urandom_range(0, 7) == 0) err_map[w + 30'($urandom_range(0, 1))] = 1'b1;
      if ($urandom_range(0, 7) == 0) idle(1'b1);
      else if ($urandom_range(0, 3) == 0) idle(1'b0);
      do_req(a, $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_i32_ifetch_mem_adapter.md
# riscv_i32_ifetch_mem_adapter

Instruction-fetch memory adapter that sits directly downstream of the pipeline-control fetch-request logic. It consumes `ifetch_req` and issues 32-bit word reads to a single-port instruction SRAM with a wait handshake. It stitches halfword-aligned instructions from up to two words and returns one 32-bit `ifetch_resp` per request. A one-word buffer avoids re-reading the most recently fetched word.

## Interface
Parameters: none.

Ports:
- clk  input  1  sole clock; all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- ifetch_req__flush_pipeline  input  1  abort any in-flight request
- ifetch_req__req_type  input  3  0 = none; any nonzero value = fetch
- ifetch_req__address  input  32  instruction address; bit 0 ignored
- ifetch_invalidate  input  1  clear word buffer (fence.i)
- mem_wait  input  1  memory cannot accept the read this cycle
- mem_read_data  input  32  read data, valid in the cycle after an accepted read
- mem_read_error  input  1  qualifies mem_read_data as faulted
- ifetch_resp__valid  output  1  response valid (single-cycle)
- ifetch_resp__data  output  32  instruction bits, aligned to bit 0
- ifetch_resp__error  output  1  fetch fault
- mem_read_enable  output  1  read request
- mem_address  output  30  word address [31:2]

## Operation
- Word A = address[31:2]. If address[1] = 0, only A is needed.
- If address[1] = 1, A and A+1 are needed; data = {word(A+1)[15:0], word(A)[31:16]}.
- A+1 is computed modulo 2^30, so 0x3FFFFFFF wraps to 0.
- Word buffer: buf_valid, buf_tag[29:0], buf_data[31:0].
  - A hit requires buf_valid and buf_tag equal to the needed word.
  - Only error-free reads are written to the buffer.
- State machine: IDLE, READ, CAPTURE, RESP.
- IDLE:
  - req_type != 0 and !flush: latch address.
  - If all needed words hit → RESP, with resp data registered.
  - Otherwise → READ, with rd_addr = first missing word.
- READ:
  - mem_read_enable = 1, mem_address = rd_addr.
  - mem_wait = 1: stay.
  - mem_wait = 0: → CAPTURE.
- CAPTURE:
  - Sample mem_read_data.
  - On error → RESP with error = 1 and data = 0.
  - Otherwise write the buffer (tag = rd_addr). If A was just read and A+1 is needed, hold A[31:16] in lo_half and → READ with rd_addr = A+1. Otherwise → RESP.
  - A straddle with the buffer holding only A+1 still reads A then A+1, because reading A overwrites the buffer.
- RESP:
  - ifetch_resp__valid = 1 unless flush is asserted this cycle.
  - → IDLE.
- Flush in READ or CAPTURE → IDLE. A read already accepted is still captured into the buffer (if error-free) but produces no response.
- ifetch_invalidate clears buf_valid. If it coincides with a CAPTURE write, the invalidate wins.
- The requester holds req_type/address stable until ifetch_resp__valid. Changes made before then without flush are undefined.

## Timing
- Reset values:
  - state IDLE, buf_valid 0, buf_tag 0, buf_data 0, lo_half 0.
  - Outputs: ifetch_resp__valid 0, ifetch_resp__data 0, ifetch_resp__error 0, mem_read_enable 0, mem_address 0.
- Reset asserted mid-transaction: immediate return to IDLE; the pending read is abandoned.
- Latency is counted from the IDLE sample cycle 0, with no waits:
  - Full hit: response in cycle 1.
  - Aligned miss: READ cycle 1, CAPTURE cycle 2, response cycle 3.
  - Straddle with A hit: response cycle 3.
  - Straddle, both miss: response cycle 5.
- Each mem_wait cycle adds one cycle per read.
- mem_address is driven 0 whenever mem_read_enable = 0.
- Maximum throughput is one response per 2 cycles (RESP → IDLE).

## Configuration
- RISCV_I32_IFETCH_WORD_BUFFER_EN defined: word buffer present, behaving as above.
- RISCV_I32_IFETCH_WORD_BUFFER_EN undefined:
  - No buffer; every request reads all needed words.
  - ifetch_invalidate is ignored.
  - Aligned latency is always 3; straddle latency is always 5.

## Test plan
- Reset, request 0x0000_1000, memory returns 0x0000_0013 → mem_address 0x400 in cycle 1, resp valid cycle 3, data 0x0000_0013, error 0. Repeat request → resp cycle 1, no mem read.
- Request 0x0000_1002, words 0x400 = 0xAAAA_BBBB and 0x401 = 0xCCCC_DDDD → two reads, data 0xDDDD_AAAA at cycle 5. Then request 0x0000_1004 → hit, data 0xCCCC_DDDD at cycle 1.
- Request 0xFFFF_FFFE → reads 0x3FFFFFFF then 0x0; data = {word0[15:0], wordTop[31:16]}.
- mem_wait held high 3 cycles on an aligned miss → mem_read_enable and mem_address stable throughout; resp at cycle 6.
- mem_read_error on the first word of a straddle → no second read; resp error 1, data 0. Same address again → refetches (buffer not written).
- Flush asserted during READ → no response, state IDLE. ifetch_invalidate after a hit → the next identical request misses and reads memory.
